// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the two SDRAM requesters, the arbiter and the SDRAM controller user port.
// slave = arbiter view, master = requester/controller environment view.
interface sdram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 21
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic [3:0]        m0_wmask;
  logic              m0_done;
  logic              m0_err;
  logic [31:0]       m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic [3:0]        m1_wmask;
  logic              m1_done;
  logic              m1_err;
  logic [31:0]       m1_rdata;

  logic              sd_req;
  logic              sd_we;
  logic [ADDR_W-1:0] sd_addr;
  logic [31:0]       sd_wdata;
  logic [3:0]        sd_wmask;
  logic              sd_ack;
  logic              sd_done;
  logic [31:0]       sd_rdata;

  logic              gnt;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wmask,
    output m0_done, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
    output m1_done, m1_err, m1_rdata,
    output sd_req, sd_we, sd_addr, sd_wdata, sd_wmask,
    input  sd_ack, sd_done, sd_rdata,
    output gnt
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wmask,
    input  m0_done, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
    input  m1_done, m1_err, m1_rdata,
    input  sd_req, sd_we, sd_addr, sd_wdata, sd_wmask,
    output sd_ack, sd_done, sd_rdata,
    input  gnt
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the SDRAM controller user port: one transaction in flight, watchdog abort.
// Define SDRAM_ARB_PRIO0_EN for fixed priority to port 0; default is round-robin.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W  = 21,
  parameter int unsigned TMO_CYC = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  sdram_port_arbiter_if.slave bus
);

  localparam int unsigned WDOG_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic              gnt_q,      gnt_d;
  logic              sd_req_q,   sd_req_d;
  logic              sd_we_q,    sd_we_d;
  logic [ADDR_W-1:0] sd_addr_q,  sd_addr_d;
  logic [31:0]       sd_wdata_q, sd_wdata_d;
  logic [3:0]        sd_wmask_q, sd_wmask_d;
  logic [WDOG_W-1:0] wdog_q,     wdog_d;
  logic              m0_done_q,  m0_done_d;
  logic              m1_done_q,  m1_done_d;
  logic              m0_err_q,   m0_err_d;
  logic              m1_err_q,   m1_err_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;

  logic              win_c;
  logic              fin_c;
  logic              abort_c;
  logic              wdog_exp_c;

`ifndef SDRAM_ARB_PRIO0_EN
  // rr_q holds the last winner; reset to 1 so port 0 takes the first tie
  logic              rr_q,       rr_d;
`endif

  always_comb begin
`ifdef SDRAM_ARB_PRIO0_EN
    win_c = !bus.m0_req;
`else
    win_c = (bus.m0_req && bus.m1_req) ? !rr_q : bus.m1_req;
`endif
  end

  assign wdog_exp_c = (wdog_q == WDOG_W'(TMO_CYC - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sd_req_d   = sd_req_q;
    sd_we_d    = sd_we_q;
    sd_addr_d  = sd_addr_q;
    sd_wdata_d = sd_wdata_q;
    sd_wmask_d = sd_wmask_q;
    wdog_d     = wdog_q;
    m0_done_d  = 1'b0;
    m1_done_d  = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    fin_c      = 1'b0;
    abort_c    = 1'b0;
`ifndef SDRAM_ARB_PRIO0_EN
    rr_d       = rr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          gnt_d      = win_c;
          sd_req_d   = 1'b1;
          sd_we_d    = win_c ? bus.m1_we    : bus.m0_we;
          sd_addr_d  = win_c ? bus.m1_addr  : bus.m0_addr;
          sd_wdata_d = win_c ? bus.m1_wdata : bus.m0_wdata;
          sd_wmask_d = win_c ? bus.m1_wmask : bus.m0_wmask;
          wdog_d     = '0;
          state_d    = S_ISSUE;
`ifndef SDRAM_ARB_PRIO0_EN
          rr_d       = win_c;
`endif
        end
      end
      S_ISSUE: begin
        if (bus.sd_ack) begin
          sd_req_d = 1'b0;
          wdog_d   = '0;
          if (bus.sd_done) begin
            fin_c   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (wdog_exp_c) begin
          // controller never accepted the command
          sd_req_d = 1'b0;
          abort_c  = 1'b1;
          state_d  = S_DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_WAIT: begin
        if (bus.sd_done) begin
          fin_c   = 1'b1;
          state_d = S_DONE;
        end else if (wdog_exp_c) begin
          abort_c = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion is routed to the port that owns the transaction
    if (fin_c || abort_c) begin
      if (gnt_q) begin
        m1_done_d  = 1'b1;
        m1_err_d   = abort_c;
        m1_rdata_d = abort_c ? 32'h0 : bus.sd_rdata;
      end else begin
        m0_done_d  = 1'b1;
        m0_err_d   = abort_c;
        m0_rdata_d = abort_c ? 32'h0 : bus.sd_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      sd_req_q   <= 1'b0;
      sd_we_q    <= 1'b0;
      sd_addr_q  <= '0;
      sd_wdata_q <= '0;
      sd_wmask_q <= '0;
      wdog_q     <= '0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sd_req_q   <= sd_req_d;
      sd_we_q    <= sd_we_d;
      sd_addr_q  <= sd_addr_d;
      sd_wdata_q <= sd_wdata_d;
      sd_wmask_q <= sd_wmask_d;
      wdog_q     <= wdog_d;
      m0_done_q  <= m0_done_d;
      m1_done_q  <= m1_done_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

`ifndef SDRAM_ARB_PRIO0_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b1;
    else        rr_q <= rr_d;
  end
`endif

  assign bus.gnt      = gnt_q;
  assign bus.sd_req   = sd_req_q;
  assign bus.sd_we    = sd_we_q;
  assign bus.sd_addr  = sd_addr_q;
  assign bus.sd_wdata = sd_wdata_q;
  assign bus.sd_wmask = sd_wmask_q;
  assign bus.m0_done  = m0_done_q;
  assign bus.m1_done  = m1_done_q;
  assign bus.m0_err   = m0_err_q;
  assign bus.m1_err   = m1_err_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (TMO_CYC = 16); honours SDRAM_ARB_PRIO0_EN when defined.
module tb_sdram_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [31:0] exp_gnt;

  sdram_port_arbiter_if #(.ADDR_W(21)) bus ();

  sdram_port_arbiter #(.ADDR_W(21), .TMO_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wmask = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wmask = '0;
    bus.sd_ack = 1'b0; bus.sd_done = 1'b0; bus.sd_rdata = '0;
    step();
    step();
    chk("rst_sd_req", 32'(bus.sd_req), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_m0_done", 32'(bus.m0_done), 32'd0);
    chk("rst_m1_done", 32'(bus.m1_done), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_sd_req", 32'(bus.sd_req), 32'd0);

    // m0 read 0x00123, ack two edges after grant edge... done three later
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 21'h00123;
    step();
    chk("rd_sd_req", 32'(bus.sd_req), 32'd1);
    chk("rd_sd_addr", 32'(bus.sd_addr), 32'h00123);
    chk("rd_sd_we", 32'(bus.sd_we), 32'd0);
    chk("rd_gnt", 32'(bus.gnt), 32'd0);
    step();
    chk("rd_sd_req_hold", 32'(bus.sd_req), 32'd1);
    bus.sd_ack = 1'b1;
    step();
    bus.sd_ack = 1'b0;
    chk("rd_sd_req_drop", 32'(bus.sd_req), 32'd0);
    step();
    step();
    chk("rd_no_early_done", 32'(bus.m0_done), 32'd0);
    bus.sd_done = 1'b1; bus.sd_rdata = 32'hDEADBEEF;
    step();
    bus.sd_done = 1'b0; bus.m0_req = 1'b0;
    chk("rd_m0_done", 32'(bus.m0_done), 32'd1);
    chk("rd_m0_err", 32'(bus.m0_err), 32'd0);
    chk("rd_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_done", 32'(bus.m1_done), 32'd0);
    step();
    chk("rd_done_pulse", 32'(bus.m0_done), 32'd0);
    step();
    chk("rd_idle_no_regrant", 32'(bus.sd_req), 32'd0);

    // m1 write at top address; m0 arrives while m1 is in flight
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 21'h1FFFFF;
    bus.m1_wdata = 32'hA5A55A5A; bus.m1_wmask = 4'b0101;
    step();
    chk("wr_gnt", 32'(bus.gnt), 32'd1);
    chk("wr_sd_req", 32'(bus.sd_req), 32'd1);
    chk("wr_sd_we", 32'(bus.sd_we), 32'd1);
    chk("wr_sd_addr", 32'(bus.sd_addr), 32'h1FFFFF);
    chk("wr_sd_wdata", bus.sd_wdata, 32'hA5A55A5A);
    chk("wr_sd_wmask", 32'(bus.sd_wmask), 32'h5);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 21'h00456;
    bus.sd_ack = 1'b1;
    step();
    bus.sd_ack = 1'b0;
    chk("wr_ack_drop", 32'(bus.sd_req), 32'd0);
    step();
    step();
    chk("wr_wait_addr", 32'(bus.sd_addr), 32'h1FFFFF);
    chk("wr_wait_wdata", bus.sd_wdata, 32'hA5A55A5A);
    chk("wr_wait_wmask", 32'(bus.sd_wmask), 32'h5);
    chk("wr_wait_gnt", 32'(bus.gnt), 32'd1);
    chk("wr_wait_no_regrant", 32'(bus.sd_req), 32'd0);
    bus.sd_done = 1'b1; bus.sd_rdata = 32'h0;
    step();
    bus.sd_done = 1'b0; bus.m1_req = 1'b0;
    chk("wr_m1_done", 32'(bus.m1_done), 32'd1);
    chk("wr_m1_err", 32'(bus.m1_err), 32'd0);
    chk("wr_m0_not_done", 32'(bus.m0_done), 32'd0);
    step();
    chk("wr_done_idle_sd_req", 32'(bus.sd_req), 32'd0);
    step();
    chk("m0_late_gnt", 32'(bus.gnt), 32'd0);
    chk("m0_late_sd_req", 32'(bus.sd_req), 32'd1);
    chk("m0_late_addr", 32'(bus.sd_addr), 32'h00456);

    // ack and done in the same cycle
    bus.sd_ack = 1'b1; bus.sd_done = 1'b1; bus.sd_rdata = 32'h13572468;
    step();
    bus.sd_ack = 1'b0; bus.sd_done = 1'b0; bus.m0_req = 1'b0;
    chk("same_m0_done", 32'(bus.m0_done), 32'd1);
    chk("same_sd_req", 32'(bus.sd_req), 32'd0);
    chk("same_rdata", bus.m0_rdata, 32'h13572468);
    step();
    chk("same_single_pulse", 32'(bus.m0_done), 32'd0);
    step();

    // watchdog abort: ack, then no sd_done for 16 edges
    bus.m0_req = 1'b1; bus.m0_addr = 21'h0AAAA;
    step();
    chk("tmo_sd_req", 32'(bus.sd_req), 32'd1);
    bus.sd_ack = 1'b1;
    step();
    bus.sd_ack = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("tmo_not_yet", 32'(bus.m0_done), 32'd0);
    step();
    bus.m0_req = 1'b0;
    chk("tmo_m0_done", 32'(bus.m0_done), 32'd1);
    chk("tmo_m0_err", 32'(bus.m0_err), 32'd1);
    chk("tmo_m0_rdata", bus.m0_rdata, 32'h0);
    step();
    chk("tmo_err_clear", 32'(bus.m0_err), 32'd0);
    bus.sd_done = 1'b1; bus.sd_rdata = 32'hFFFFFFFF;
    step();
    bus.sd_done = 1'b0;
    step();
    chk("late_done_m0", 32'(bus.m0_done), 32'd0);
    chk("late_done_m1", 32'(bus.m1_done), 32'd0);
    chk("late_done_rdata", bus.m0_rdata, 32'h0);
    chk("late_done_sd_req", 32'(bus.sd_req), 32'd0);

    // reset in the middle of WAIT
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 21'h00321;
    step();
    bus.sd_ack = 1'b1;
    step();
    bus.sd_ack = 1'b0;
    step();
    chk("mid_gnt_before", 32'(bus.gnt), 32'd1);
    bus.m1_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sd_req", 32'(bus.sd_req), 32'd0);
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_m1_done", 32'(bus.m1_done), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // both ports requesting continuously for six transactions
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 21'h00010;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 21'h00020;
    for (int i = 0; i < 6; i++) begin
`ifdef SDRAM_ARB_PRIO0_EN
      exp_gnt = 32'd0;
`else
      exp_gnt = 32'(i % 2);
`endif
      step();
      chk($sformatf("rr_gnt_%0d", i), 32'(bus.gnt), exp_gnt);
      chk($sformatf("rr_sd_addr_%0d", i), 32'(bus.sd_addr), (exp_gnt == 32'd0) ? 32'h10 : 32'h20);
      bus.sd_ack = 1'b1; bus.sd_done = 1'b1; bus.sd_rdata = 32'hC0DE0000 + 32'(i);
      step();
      bus.sd_ack = 1'b0; bus.sd_done = 1'b0;
      chk($sformatf("rr_done_%0d", i), {30'd0, bus.m1_done, bus.m0_done},
          (exp_gnt == 32'd0) ? 32'd1 : 32'd2);
      step();
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
